cordic_pipe_hs: RTL

//  Parametrised, fully pipelined CORDIC engine with valid/ready handshake and global stall.

---
 rtl/cordic_pkg.sv | 46 ++++
 rtl/cordic_iter_stage.sv | 72 +++++++
 rtl/cordic_pipe_hs.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and fixed-point helpers for the pipelined CORDIC engine.
// Angles are held at 32 fractional bits and rounded to the datapath precision at elaboration.
package cordic_pkg;

    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_VECTOR = 1'b1;

    localparam longint PI_Q32      = 64'sd13493037705;
    localparam longint PI_HALF_Q32 = PI_Q32 >>> 1;
    localparam longint KINV_Q30    = 64'sd652032874;

    localparam int unsigned ATAN_ENTRIES = 24;

    // atan(2^-i) in radians, 32 fractional bits
    localparam longint ATAN_TABLE [ATAN_ENTRIES] = '{
        64'sd3373259426, 64'sd1991351318, 64'sd1052175346, 64'sd534100635,
        64'sd268086748,  64'sd134174063,  64'sd67103403,   64'sd33553749,
        64'sd16777131,   64'sd8388597,    64'sd4194303,    64'sd2097152,
        64'sd1048576,    64'sd524288,     64'sd262144,     64'sd131072,
        64'sd65536,      64'sd32768,      64'sd16384,      64'sd8192,
        64'sd4096,       64'sd2048,       64'sd1024,       64'sd512
    };

    // Arithmetic right shift with round-half-up.
    function automatic longint round_shr(input longint v, input int unsigned sh);
        longint bias;
        bias = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
        return (v + bias) >>> sh;
    endfunction

    // Clamp to the two's complement range of a w-bit signed value.
    function automatic longint saturate(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT); loads only when en_i is high.
module cordic_iter_stage
    import cordic_pkg::*;
#(
    parameter int unsigned                  WIDTH_INT = 20,
    parameter int unsigned                  SHIFT     = 0,
    parameter logic signed [WIDTH_INT-1:0]  ATAN      = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en_i,
    input  logic                        valid_i,
    input  logic                        mode_i,
    input  logic signed [WIDTH_INT-1:0] x_i,
    input  logic signed [WIDTH_INT-1:0] y_i,
    input  logic signed [WIDTH_INT-1:0] z_i,
    output logic                        valid_o,
    output logic                        mode_o,
    output logic signed [WIDTH_INT-1:0] x_o,
    output logic signed [WIDTH_INT-1:0] y_o,
    output logic signed [WIDTH_INT-1:0] z_o
);

    logic                        valid_d, valid_q;
    logic                        mode_d, mode_q;
    logic signed [WIDTH_INT-1:0] x_d, x_q;
    logic signed [WIDTH_INT-1:0] y_d, y_q;
    logic signed [WIDTH_INT-1:0] z_d, z_q;
    logic signed [WIDTH_INT-1:0] x_sh, y_sh;
    logic                        dir_pos;

    always_comb begin
        valid_d = valid_i;
        mode_d  = mode_i;
        x_sh    = x_i >>> SHIFT;
        y_sh    = y_i >>> SHIFT;
        // ROTATE drives z to zero, VECTOR drives y to zero
        dir_pos = (mode_i == MODE_ROTATE) ? ~z_i[WIDTH_INT-1] : y_i[WIDTH_INT-1];
        if (dir_pos) begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
            z_d = z_i - ATAN;
        end else begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
            z_d = z_i + ATAN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule

// File: rtl/cordic_pipe_hs.sv
// Pipelined CORDIC with per-sample ROTATE/VECTOR mode: quadrant fold, STAGES micro-rotations
// and a 1/K gain stage, all stalled together by a single advance enable from the output side.
module cordic_pipe_hs
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned STAGES = 12,
    parameter int unsigned GUARD  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z
);

    localparam int unsigned W_INT = WIDTH + 2 * GUARD;
    localparam int unsigned FB    = FRAC + GUARD;
    localparam int unsigned KW    = FB + 2;
    localparam int unsigned PW    = W_INT + KW;

    localparam logic signed [W_INT-1:0] PI_HALF_I = W_INT'(round_shr(PI_HALF_Q32, 32 - FB));
    localparam logic signed [KW-1:0]    KINV_I    = KW'(round_shr(KINV_Q30, 30 - FB));

    logic adv;

    logic                    out_valid_d, out_valid_q;
    logic                    out_mode_d, out_mode_q;
    logic signed [WIDTH-1:0] out_x_d, out_x_q;
    logic signed [WIDTH-1:0] out_y_d, out_y_q;
    logic signed [WIDTH-1:0] out_z_d, out_z_q;

    // A stalled output freezes every stage, so nothing inside can overrun it.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // ---------------------------------------------------------------- fold stage
    logic signed [W_INT-1:0] x_in, y_in, z_in;
    logic                    f_valid_d, f_valid_q;
    logic                    f_mode_d, f_mode_q;
    logic signed [W_INT-1:0] f_x_d, f_x_q;
    logic signed [W_INT-1:0] f_y_d, f_y_q;
    logic signed [W_INT-1:0] f_z_d, f_z_q;

    always_comb begin
        x_in      = W_INT'(in_x) <<< GUARD;
        y_in      = W_INT'(in_y) <<< GUARD;
        z_in      = W_INT'(in_z) <<< GUARD;
        f_valid_d = in_valid;
        f_mode_d  = in_mode;
        f_x_d     = x_in;
        f_y_d     = y_in;
        f_z_d     = z_in;
        if (in_mode == MODE_ROTATE) begin
            if (z_in > PI_HALF_I) begin
                f_x_d = -y_in;
                f_y_d = x_in;
                f_z_d = z_in - PI_HALF_I;
            end else if (z_in < -PI_HALF_I) begin
                f_x_d = y_in;
                f_y_d = -x_in;
                f_z_d = z_in + PI_HALF_I;
            end
        end else begin
            f_z_d = '0;
            // Left half-plane is rotated into the right one; the angle used is pre-loaded in z.
            if (x_in[W_INT-1]) begin
                if (!y_in[W_INT-1]) begin
                    f_x_d = y_in;
                    f_y_d = -x_in;
                    f_z_d = PI_HALF_I;
                end else begin
                    f_x_d = -y_in;
                    f_y_d = x_in;
                    f_z_d = -PI_HALF_I;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            f_valid_q <= 1'b0;
            f_mode_q  <= 1'b0;
            f_x_q     <= '0;
            f_y_q     <= '0;
            f_z_q     <= '0;
        end else if (adv) begin
            f_valid_q <= f_valid_d;
            f_mode_q  <= f_mode_d;
            f_x_q     <= f_x_d;
            f_y_q     <= f_y_d;
            f_z_q     <= f_z_d;
        end
    end

    // ---------------------------------------------------------------- micro-rotations
    logic                    s_valid [STAGES+1];
    logic                    s_mode  [STAGES+1];
    logic signed [W_INT-1:0] s_x     [STAGES+1];
    logic signed [W_INT-1:0] s_y     [STAGES+1];
    logic signed [W_INT-1:0] s_z     [STAGES+1];

    assign s_valid[0] = f_valid_q;
    assign s_mode[0]  = f_mode_q;
    assign s_x[0]     = f_x_q;
    assign s_y[0]     = f_y_q;
    assign s_z[0]     = f_z_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_iter
        localparam logic signed [W_INT-1:0] ATAN_I = W_INT'(round_shr(ATAN_TABLE[i], 32 - FB));

        cordic_iter_stage #(
            .WIDTH_INT (W_INT),
            .SHIFT     (i),
            .ATAN      (ATAN_I)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .en_i    (adv),
            .valid_i (s_valid[i]),
            .mode_i  (s_mode[i]),
            .x_i     (s_x[i]),
            .y_i     (s_y[i]),
            .z_i     (s_z[i]),
            .valid_o (s_valid[i+1]),
            .mode_o  (s_mode[i+1]),
            .x_o     (s_x[i+1]),
            .y_o     (s_y[i+1]),
            .z_o     (s_z[i+1])
        );
    end

    // ---------------------------------------------------------------- gain stage
    logic signed [PW-1:0] prod_x, prod_y;

    always_comb begin
        prod_x      = PW'(s_x[STAGES]) * PW'(KINV_I);
        prod_y      = PW'(s_y[STAGES]) * PW'(KINV_I);
        out_valid_d = s_valid[STAGES];
        out_mode_d  = s_mode[STAGES];
        // Product carries 2*FB fractional bits; keep FRAC.
        out_x_d     = WIDTH'(saturate(round_shr(longint'(prod_x), FB + GUARD), WIDTH));
        out_y_d     = WIDTH'(saturate(round_shr(longint'(prod_y), FB + GUARD), WIDTH));
        out_z_d     = WIDTH'(saturate(round_shr(longint'(s_z[STAGES]), GUARD), WIDTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
        end else if (adv) begin
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule
